// File: rtl/uart_reg_access_arbiter.sv
// uart_reg_access_arbiter
// Serialises register accesses from two requesters (0 = host, 1 = UART engine)
// onto the shared decoder/register-file path. Each granted access runs
// IDLE -> SETUP -> STROBE (STROBE_CYCLES cycles) -> ACK.
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it requester 0 has fixed priority.
//
// state  | meaning
// IDLE   | waiting for a request, arbitration happens here
// SETUP  | address/write data driven, decoder enable low so it settles
// STROBE | decoder enabled, write strobe follows latched wr
// ACK    | one-cycle completion pulse to the granted requester
module uart_reg_access_arbiter #(
  parameter int STROBE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] addr0,
  input  logic [2:0] addr1,
  input  logic       wr0,
  input  logic       wr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic [2:0] addressOut,
  output logic       decodeEnable,
  output logic       writeStrobe,
  output logic [7:0] writeData,
  input  logic [7:0] regReadData,
  output logic       busy,
  output logic       grantId
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, ACK} state_t;

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  state_t     state;
  state_t     next_state;
  logic [3:0] strobe_cnt;
  logic       wr_lat;
  logic       win;

`ifdef ARB_ROUND_ROBIN_EN
  logic       last_grant;
`endif

  // Next-state decode and arbitration winner (only consumed in IDLE).
  always_comb begin
    next_state = state;
    win        = 1'b0;
    case (state)
      IDLE:    if (req0 || req1) next_state = SETUP;
      SETUP:   next_state = STROBE;
      STROBE:  if (strobe_cnt == 4'd0) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
`ifdef ARB_ROUND_ROBIN_EN
    if (req0 && req1) win = ~last_grant;
    else              win = ~req0;
`else
    win = ~req0;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Registered outputs, transaction latch, strobe down-counter and read capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      addressOut   <= 3'd0;
      decodeEnable <= 1'b0;
      writeStrobe  <= 1'b0;
      writeData    <= 8'd0;
      rdata        <= 8'd0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      busy         <= 1'b0;
      grantId      <= 1'b0;
      wr_lat       <= 1'b0;
      strobe_cnt   <= 4'd0;
    end else begin
      decodeEnable <= (next_state == STROBE);
      writeStrobe  <= (next_state == STROBE) && wr_lat;
      ack0         <= (next_state == ACK) && !grantId;
      ack1         <= (next_state == ACK) && grantId;
      busy         <= (next_state != IDLE);
      // addressOut only moves on entry to SETUP, when decodeEnable is low.
      if (state == IDLE && next_state == SETUP) begin
        grantId    <= win;
        addressOut <= win ? addr1  : addr0;
        writeData  <= win ? wdata1 : wdata0;
        wr_lat     <= win ? wr1    : wr0;
      end
      if (state == SETUP)
        strobe_cnt <= STROBE_LOAD;
      else if (state == STROBE && strobe_cnt != 4'd0)
        strobe_cnt <= strobe_cnt - 4'd1;
      if (state == STROBE && strobe_cnt == 4'd0 && !wr_lat)
        rdata <= regReadData;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember the last winner so contention alternates; starts at 1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (reset)                                  last_grant <= 1'b1;
    else if (state == IDLE && next_state == SETUP) last_grant <= win;
  end
`endif

endmodule

// File: tb/tb_uart_reg_access_arbiter.sv
module tb_uart_reg_access_arbiter;

  localparam int SC = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // DUT with STROBE_CYCLES = 1
  logic req0 = 0, req1 = 0, wr0 = 0, wr1 = 0;
  logic [2:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0, regReadData = 0;
  logic ack0, ack1, decodeEnable, writeStrobe, busy, grantId;
  logic [7:0] rdata, writeData;
  logic [2:0] addressOut;

  uart_reg_access_arbiter #(.STROBE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wr0(wr0), .wr1(wr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .addressOut(addressOut),
    .decodeEnable(decodeEnable), .writeStrobe(writeStrobe), .writeData(writeData),
    .regReadData(regReadData), .busy(busy), .grantId(grantId));

  // DUT with STROBE_CYCLES = 3
  logic b_req0 = 0, b_req1 = 0, b_wr0 = 0, b_wr1 = 0;
  logic [2:0] b_addr0 = 0, b_addr1 = 0;
  logic [7:0] b_wdata0 = 0, b_wdata1 = 0, b_regReadData = 0;
  logic b_ack0, b_ack1, b_decodeEnable, b_writeStrobe, b_busy, b_grantId;
  logic [7:0] b_rdata, b_writeData;
  logic [2:0] b_addressOut;

  uart_reg_access_arbiter #(.STROBE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0(b_req0), .req1(b_req1), .addr0(b_addr0), .addr1(b_addr1),
    .wr0(b_wr0), .wr1(b_wr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
    .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata), .addressOut(b_addressOut),
    .decodeEnable(b_decodeEnable), .writeStrobe(b_writeStrobe), .writeData(b_writeData),
    .regReadData(b_regReadData), .busy(b_busy), .grantId(b_grantId));

  int checks = 0;
  int failures = 0;

  // Transaction-level reference model: phase 0 idle, 1 setup, 2..SC+1 strobe, SC+2 ack
  int         m_phase;
  logic       m_gid, m_last, m_wr;
  logic [2:0] m_addr;
  logic [7:0] m_wdata, m_rdata;

  task automatic model_reset;
    m_phase = 0; m_gid = 0; m_last = 1; m_wr = 0;
    m_addr = 0; m_wdata = 0; m_rdata = 0;
  endtask

  task automatic model_step;
    logic w;
    if (m_phase == 0) begin
      if (req0 || req1) begin
`ifdef ARB_ROUND_ROBIN_EN
        w = (req0 && req1) ? !m_last : !req0;
`else
        w = !req0;
`endif
        m_gid = w; m_last = w;
        m_addr  = w ? addr1 : addr0;
        m_wr    = w ? wr1 : wr0;
        m_wdata = w ? wdata1 : wdata0;
        m_phase = 1;
      end
    end else if (m_phase == SC + 2) begin
      m_phase = 0;
    end else begin
      if (m_phase == SC + 1 && !m_wr) m_rdata = regReadData;
      m_phase++;
    end
  endtask

  task automatic do_reset;
    reset = 1;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; addr0 = 0; addr1 = 0;
    wdata0 = 0; wdata1 = 0; regReadData = 0;
    b_req0 = 0; b_req1 = 0; b_wr0 = 0; b_wr1 = 0; b_addr0 = 0; b_addr1 = 0;
    b_wdata0 = 0; b_wdata1 = 0; b_regReadData = 0;
    @(negedge clk); @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({addressOut, decodeEnable, writeStrobe, writeData, rdata} !== 21'd0) begin
      failures++;
      $display("FAIL reset_datapath actual=%0h expected=0", {addressOut, decodeEnable, writeStrobe, writeData, rdata});
    end
    checks++;
    if ({ack0, ack1, busy, grantId} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl actual=%b expected=0000", {ack0, ack1, busy, grantId});
    end
    checks++;
    if ({b_ack1, b_busy, b_decodeEnable, b_rdata} !== 11'd0) begin
      failures++;
      $display("FAIL reset_dut3 actual=%0h expected=0", {b_ack1, b_busy, b_decodeEnable, b_rdata});
    end
  endtask

  task automatic test_single_read;
    do_reset();
    req0 = 1; addr0 = 3'b101; wr0 = 0; regReadData = 8'hA5;
    @(negedge clk);  // t+1 SETUP
    checks++;
    if ({busy, decodeEnable, addressOut, grantId} !== {1'b1, 1'b0, 3'd5, 1'b0}) begin
      failures++;
      $display("FAIL read_setup actual=%b expected=%b", {busy, decodeEnable, addressOut, grantId}, {1'b1, 1'b0, 3'd5, 1'b0});
    end
    @(negedge clk);  // t+2 STROBE
    checks++;
    if ({decodeEnable, writeStrobe, addressOut, ack0} !== {1'b1, 1'b0, 3'd5, 1'b0}) begin
      failures++;
      $display("FAIL read_strobe actual=%b expected=%b", {decodeEnable, writeStrobe, addressOut, ack0}, {1'b1, 1'b0, 3'd5, 1'b0});
    end
    @(negedge clk);  // t+3 ACK
    checks++;
    if ({ack0, ack1, decodeEnable, rdata} !== {1'b1, 1'b0, 1'b0, 8'hA5}) begin
      failures++;
      $display("FAIL read_ack actual=%0h expected=%0h", {ack0, ack1, decodeEnable, rdata}, {1'b1, 1'b0, 1'b0, 8'hA5});
    end
    req0 = 0;
    regReadData = 8'h11;
    @(negedge clk);  // t+4 IDLE
    checks++;
    if ({busy, ack0, rdata} !== {1'b0, 1'b0, 8'hA5}) begin
      failures++;
      $display("FAIL read_idle actual=%0h expected=%0h", {busy, ack0, rdata}, {1'b0, 1'b0, 8'hA5});
    end
  endtask

  task automatic test_write_sc3;
    int strobes, ack_at, bad_wd;
    do_reset();
    b_req1 = 1; b_addr1 = 3'b010; b_wr1 = 1; b_wdata1 = 8'h3C; b_regReadData = 8'hFF;
    strobes = 0; ack_at = -1; bad_wd = 0;
    for (int c = 1; c <= 12 && ack_at < 0; c++) begin
      @(negedge clk);
      if (b_decodeEnable && b_writeStrobe) strobes++;
      if (b_decodeEnable && (b_writeData !== 8'h3C || b_addressOut !== 3'd2)) bad_wd++;
      if (b_ack1) begin ack_at = c; b_req1 = 0; end
    end
    checks++;
    if (strobes != 3) begin
      failures++;
      $display("FAIL write_strobe_count actual=%0d expected=3", strobes);
    end
    checks++;
    if (ack_at != 5) begin
      failures++;
      $display("FAIL write_ack_cycle actual=%0d expected=5", ack_at);
    end
    checks++;
    if (bad_wd != 0) begin
      failures++;
      $display("FAIL write_data_bad_cycles actual=%0d expected=0", bad_wd);
    end
    checks++;
    if ({b_rdata, b_grantId} !== {8'h00, 1'b1}) begin
      failures++;
      $display("FAIL write_rdata_gid actual=%0h expected=%0h", {b_rdata, b_grantId}, {8'h00, 1'b1});
    end
  endtask

  task automatic test_contention;
    int n, exp_id;
    int ids[4];
    int cycs[4];
    do_reset();
    req0 = 1; req1 = 1; addr0 = 3'd1; addr1 = 3'd6; wr0 = 0; wr1 = 0;
    n = 0;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin ids[n] = int'(ack1); cycs[n] = c; n++; end
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL contention_ack_count actual=%0d expected=4", n);
    end
    for (int i = 0; i < n; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_id = i % 2;
`else
      exp_id = 0;
`endif
      checks++;
      if (ids[i] != exp_id) begin
        failures++;
        $display("FAIL contention_grant_%0d actual=%0d expected=%0d", i, ids[i], exp_id);
      end
    end
    for (int i = 1; i < n; i++) begin
      checks++;
      if (cycs[i] - cycs[i-1] != SC + 3) begin
        failures++;
        $display("FAIL contention_spacing_%0d actual=%0d expected=%0d", i, cycs[i] - cycs[i-1], SC + 3);
      end
    end
    req0 = 0; req1 = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid_strobe;
    int ack_at;
    do_reset();
    req0 = 1; addr0 = 3'd3; wr0 = 1; wdata0 = 8'h55;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({decodeEnable, writeStrobe} !== 2'b11) begin
      failures++;
      $display("FAIL midrst_in_strobe actual=%b expected=11", {decodeEnable, writeStrobe});
    end
    reset = 1;
    @(negedge clk);
    checks++;
    if ({decodeEnable, writeStrobe, busy, ack0, ack1, addressOut} !== 8'd0) begin
      failures++;
      $display("FAIL midrst_abort actual=%b expected=0", {decodeEnable, writeStrobe, busy, ack0, ack1, addressOut});
    end
    reset = 0;
    ack_at = -1;
    for (int c = 1; c <= 10 && ack_at < 0; c++) begin
      @(negedge clk);
      if (ack0) begin ack_at = c; req0 = 0; end
    end
    checks++;
    if (ack_at != SC + 2) begin
      failures++;
      $display("FAIL midrst_recover_ack actual=%0d expected=%0d", ack_at, SC + 2);
    end
  endtask

  task automatic test_late_request;
    int ack_at;
    bit found;
    do_reset();
    req0 = 1; addr0 = 3'd2; wr0 = 0;
    @(negedge clk);  // SETUP for requester 0
    req1 = 1; addr1 = 3'd4; wr1 = 1; wdata1 = 8'h77;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (ack0) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL late_ack0 actual=0 expected=1");
    end
    req0 = 0;
    ack_at = -1;
    for (int c = 1; c <= 10 && ack_at < 0; c++) begin
      @(negedge clk);
      if (ack1) begin
        ack_at = c;
        req1 = 0;
        checks++;
        if (grantId !== 1'b1) begin
          failures++;
          $display("FAIL late_grant actual=%b expected=1", grantId);
        end
      end
    end
    checks++;
    if (ack_at != SC + 3) begin
      failures++;
      $display("FAIL late_ack1_cycle actual=%0d expected=%0d", ack_at, SC + 3);
    end
  endtask

  task automatic test_random;
    logic e_dec, e_ws, e_ack0, e_ack1, e_busy;
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      e_dec  = (m_phase >= 2) && (m_phase <= SC + 1);
      e_ws   = e_dec && m_wr;
      e_ack0 = (m_phase == SC + 2) && !m_gid;
      e_ack1 = (m_phase == SC + 2) && m_gid;
      e_busy = (m_phase != 0);
      checks++;
      if ({decodeEnable, writeStrobe, ack0, ack1, busy, grantId} !== {e_dec, e_ws, e_ack0, e_ack1, e_busy, m_gid}) begin
        failures++;
        $display("FAIL rand_ctrl cyc=%0d actual=%b expected=%b", cyc,
                 {decodeEnable, writeStrobe, ack0, ack1, busy, grantId}, {e_dec, e_ws, e_ack0, e_ack1, e_busy, m_gid});
      end
      checks++;
      if ({addressOut, writeData, rdata} !== {m_addr, m_wdata, m_rdata}) begin
        failures++;
        $display("FAIL rand_data cyc=%0d actual=%0h expected=%0h", cyc,
                 {addressOut, writeData, rdata}, {m_addr, m_wdata, m_rdata});
      end
      // requester agents, driven from the model's view of acknowledgement
      if (e_ack0) req0 = 0;
      else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1; addr0 = 3'($urandom); wr0 = 1'($urandom); wdata0 = 8'($urandom);
      end
      if (e_ack1) req1 = 0;
      else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1; addr1 = 3'($urandom); wr1 = 1'($urandom); wdata1 = 8'($urandom);
      end
      regReadData = 8'($urandom);
      model_step();
      @(negedge clk);
    end
    req0 = 0; req1 = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_sc3();
    test_contention();
    test_reset_mid_strobe();
    test_late_request();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_reg_access_arbiter.md
# uart_reg_access_arbiter

Sequences and shares the UART register-select path between two requesters: requester 0 (host/software side) and requester 1 (UART TX/RX engine). It serialises register accesses. For each granted transaction it drives the 3-bit register address and enable into the 3-to-8 address decoder, then strobes the access and returns an acknowledge with read data. It sits between the requesters and the decoder/register file inside the software-defined UART.

## Interface
- STROBE_CYCLES, 1: number of cycles the decoder enable is held per access. Legal range is 1..15.

- clk  input  1  single system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- req0, req1  input  1  access request from requester 0 / 1
- addr0, addr1  input  3  register address from requester 0 / 1
- wr0, wr1  input  1  1 = write, 0 = read
- wdata0, wdata1  input  8  write data
- ack0, ack1  output  1  one-cycle completion pulse to requester 0 / 1
- rdata  output  8  read data, valid while the corresponding ack is high
- addressOut  output  3  register address to the decoder
- decodeEnable  output  1  decoder enable
- writeStrobe  output  1  write strobe to the register file
- writeData  output  8  write data to the register file
- regReadData  input  8  register file read data (selected by the decoder)
- busy  output  1  high in any state other than IDLE
- grantId  output  1  requester currently or most recently granted

## Operation
- FSM states: IDLE, SETUP, STROBE, ACK.
- IDLE: if any req is high, pick a winner, latch its addr/wr/wdata, set grantId, and go to SETUP. Otherwise stay in IDLE.
- SETUP (1 cycle): addressOut and writeData are driven; decodeEnable = 0 so the decoder output settles. Next state is STROBE.
- STROBE (STROBE_CYCLES cycles, 4-bit down-counter):
  - decodeEnable = 1.
  - writeStrobe = latched wr.
  - On the last STROBE cycle, regReadData is registered into rdata (reads only; writes leave rdata unchanged).
  - Next state is ACK.
- ACK (1 cycle): the ack of the granted requester is 1; decodeEnable = writeStrobe = 0; addressOut holds its value. Next state is IDLE.
- Requester rules:
  - Hold req/addr/wr/wdata stable from assertion until ack is seen.
  - Deassert req on the edge ending ack. A req still high in IDLE is a new transaction.
- Requests arriving while busy are not lost: they wait in IDLE arbitration. A non-granted requester stays pending, with no ack.
- Arbitration on simultaneous req0 and req1 in IDLE depends on ARB_ROUND_ROBIN_EN (see Configuration).
- Reset values:
  - state = IDLE.
  - addressOut = 0, decodeEnable = 0, writeStrobe = 0, writeData = 0, rdata = 0.
  - ack0 = ack1 = 0, busy = 0, grantId = 0.
  - Internal last-grant register = 1.
- Reset mid-transaction:
  - Abort at the next edge: all outputs return to reset values.
  - No ack is issued, and a write in progress is cut off.
  - The requester must re-request.

## Timing
- req sampled high in IDLE at cycle t gives:
  - SETUP at t+1.
  - STROBE at t+2 .. t+1+STROBE_CYCLES.
  - ACK at t+2+STROBE_CYCLES.
  - IDLE at t+3+STROBE_CYCLES.
- Back-to-back throughput: one transaction per STROBE_CYCLES+3 cycles. With the default, that is 4 cycles.
- All outputs are registered; there is no combinational path from req to ack or from regReadData to rdata.
- decodeEnable is never high in the same cycle that addressOut changes.

## Configuration
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. On simultaneous requests, grant the requester not granted last. The last-grant register resets to 1, so requester 0 wins the first contention. A lone requester is always granted.
- Undefined: fixed priority, where requester 0 always wins contention. Requester 1 can starve, and the last-grant register is not implemented.

## Test plan
- Single read, STROBE_CYCLES = 1:
  - Stimulus: req0 = 1, addr0 = 3'b101, wr0 = 0, regReadData = 8'hA5.
  - Response: SETUP at t+1; decodeEnable high only at t+2 with addressOut = 5; ack0 at t+3 with rdata = 8'hA5; busy low at t+4.
- Single write, STROBE_CYCLES = 3:
  - Stimulus: req1 = 1, addr1 = 3'b010, wr1 = 1, wdata1 = 8'h3C.
  - Response: writeStrobe and decodeEnable high for exactly 3 cycles with writeData = 8'h3C; ack1 at t+5; rdata unchanged.
- Contention, macro defined:
  - Stimulus: req0 and req1 held high, each re-asserted after its ack.
  - Response: grant order 0,1,0,1; acks spaced 4 cycles apart.
- Contention, macro undefined:
  - Stimulus: same as the previous scenario.
  - Response: only ack0 pulses; ack1 stays 0 while req0 is re-asserted.
- Reset mid-STROBE:
  - Stimulus: assert reset during a STROBE cycle.
  - Response: at the next edge decodeEnable = 0, writeStrobe = 0, busy = 0, and no ack. After reset is released with req0 still high, a full transaction completes normally.
- Late request:
  - Stimulus: req1 asserted while requester 0's transaction is in SETUP.
  - Response: req1 is granted in the IDLE cycle after ack0 and is acked 3 cycles later (STROBE_CYCLES = 1).
